// File: rtl/lieat_exu_trap_ctrl_pkg.sv
// Shared definitions for the EXU trap sequencer: FSM state encodings,
// machine-mode cause codes and the position of the mcause interrupt bit.
package lieat_exu_trap_ctrl_pkg;

  typedef enum logic [1:0] {
    TRAP_IDLE   = 2'd0,
    TRAP_HOLD   = 2'd1,
    TRAP_COMMIT = 2'd2
  } trap_state_e;

  localparam int CAUSE_ECALL_M = 11;
  localparam int CAUSE_MSI     = 3;
  localparam int CAUSE_MTI     = 7;

  // The mcause interrupt flag sits in the top bit of the register.
  function automatic int irq_bit_pos(input int xlen);
    return xlen - 1;
  endfunction

endpackage

// File: rtl/lieat_exu_trap_ctrl.sv
// Trap sequencer in front of the CSR file. Arbitrates ecall, mret and the
// machine software/timer interrupts, runs the IFU hold handshake for
// interrupts, and issues a one-cycle commit pulse together with a flush.
// Every output is a flop whose next value is derived from the next state,
// so a commit pulse appears on the cycle after the deciding input.
module lieat_exu_trap_ctrl
  import lieat_exu_trap_ctrl_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int HOLD_TMO = 16
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            csr_valid,
  input  logic            csr_ecall,
  input  logic            csr_mret,
  input  logic [XLEN-1:0] csr_pc,
  input  logic            mstatus_mie,
  input  logic            msip_req,
  input  logic            mtip_req,
  input  logic [XLEN-1:0] mtvec_pc,
  input  logic [XLEN-1:0] mepc_pc,
  output logic            if_hold_req,
  input  logic            if_hold_rsp,
  input  logic [XLEN-1:0] if_hold_pc,
  output logic            exu_stall,
  output logic            trap_commit,
  output logic            mret_commit,
  output logic [XLEN-1:0] trap_cause,
  output logic [XLEN-1:0] trap_epc,
  output logic            flush_req,
  output logic [XLEN-1:0] flush_pc
);

  localparam int              TMO_W    = $clog2(HOLD_TMO);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(HOLD_TMO - 1);
  localparam int              IRQ_BIT  = irq_bit_pos(XLEN);
  localparam logic [XLEN-1:0] IRQ_FLAG = XLEN'(1) << IRQ_BIT;

  localparam logic [XLEN-1:0] CAUSE_ECALL_V = XLEN'(CAUSE_ECALL_M);
  localparam logic [XLEN-1:0] CAUSE_MSI_V   = IRQ_FLAG | XLEN'(CAUSE_MSI);
  localparam logic [XLEN-1:0] CAUSE_MTI_V   = IRQ_FLAG | XLEN'(CAUSE_MTI);

  trap_state_e       state_q, state_d;
  logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic [XLEN-1:0]   cause_q, cause_d;

  logic              go_trap;
  logic              go_mret;
  logic [XLEN-1:0]   commit_epc;
  logic              src_live;

  logic              if_hold_req_q, if_hold_req_d;
  logic              exu_stall_q,   exu_stall_d;
  logic              trap_commit_q, trap_commit_d;
  logic              mret_commit_q, mret_commit_d;
  logic [XLEN-1:0]   trap_cause_q,  trap_cause_d;
  logic [XLEN-1:0]   trap_epc_q,    trap_epc_d;
  logic              flush_req_q,   flush_req_d;
  logic [XLEN-1:0]   flush_pc_q,    flush_pc_d;

  // The low mtvec bits carry the mode field; only direct mode is supported.
  logic unused_mtvec_mode;
  assign unused_mtvec_mode = &{1'b0, mtvec_pc[1:0]};

  // The interrupt that opened the hold is still requested and still enabled.
  assign src_live = mstatus_mie &&
                    ((cause_q == CAUSE_MSI_V) ? msip_req : mtip_req);

  // State register and hold timeout counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= TRAP_IDLE;
      tmo_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  // Latched cause: only consumed while in HOLD, so it needs no reset.
  always_ff @(posedge clock) begin
    cause_q <= cause_d;
  end

  // Next-state logic: IDLE arbitration, hold handshake, single-cycle commit.
  always_comb begin
    state_d    = state_q;
    tmo_cnt_d  = tmo_cnt_q;
    cause_d    = cause_q;
    go_trap    = 1'b0;
    go_mret    = 1'b0;
    commit_epc = '0;
    unique case (state_q)
      TRAP_IDLE: begin
        if (csr_valid && csr_ecall) begin
          go_trap    = 1'b1;
          cause_d    = CAUSE_ECALL_V;
          commit_epc = csr_pc;
          state_d    = TRAP_COMMIT;
        end else if (csr_valid && csr_mret) begin
          go_mret = 1'b1;
          state_d = TRAP_COMMIT;
        end else if (mstatus_mie && msip_req) begin
          cause_d   = CAUSE_MSI_V;
          tmo_cnt_d = '0;
          state_d   = TRAP_HOLD;
        end else if (mstatus_mie && mtip_req) begin
          cause_d   = CAUSE_MTI_V;
          tmo_cnt_d = '0;
          state_d   = TRAP_HOLD;
        end
      end
      TRAP_HOLD: begin
        // A response in the same cycle as an abort or timeout still commits.
        if (if_hold_rsp) begin
          go_trap    = 1'b1;
          commit_epc = if_hold_pc;
          state_d    = TRAP_COMMIT;
        end else if (!src_live || (tmo_cnt_q == TMO_LAST)) begin
          tmo_cnt_d = '0;
          state_d   = TRAP_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end
      TRAP_COMMIT: begin
        state_d = TRAP_IDLE;
      end
      default: begin
        state_d = TRAP_IDLE;
      end
    endcase
  end

  // Output next-values, derived from the transition being taken.
  always_comb begin
    if_hold_req_d = (state_d == TRAP_HOLD);
    exu_stall_d   = (state_d != TRAP_IDLE);
    trap_commit_d = go_trap;
    mret_commit_d = go_mret;
    flush_req_d   = go_trap | go_mret;
    trap_cause_d  = go_trap ? cause_d : '0;
    trap_epc_d    = go_trap ? commit_epc : '0;
    flush_pc_d    = '0;
    if (go_trap) begin
      flush_pc_d = {mtvec_pc[XLEN-1:2], 2'b00};
    end else if (go_mret) begin
      flush_pc_d = mepc_pc;
    end
  end

  // Output registers; reset clears them immediately, so no partial commit leaks.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      if_hold_req_q <= 1'b0;
      exu_stall_q   <= 1'b0;
      trap_commit_q <= 1'b0;
      mret_commit_q <= 1'b0;
      trap_cause_q  <= '0;
      trap_epc_q    <= '0;
      flush_req_q   <= 1'b0;
      flush_pc_q    <= '0;
    end else begin
      if_hold_req_q <= if_hold_req_d;
      exu_stall_q   <= exu_stall_d;
      trap_commit_q <= trap_commit_d;
      mret_commit_q <= mret_commit_d;
      trap_cause_q  <= trap_cause_d;
      trap_epc_q    <= trap_epc_d;
      flush_req_q   <= flush_req_d;
      flush_pc_q    <= flush_pc_d;
    end
  end

  assign if_hold_req = if_hold_req_q;
  assign exu_stall   = exu_stall_q;
  assign trap_commit = trap_commit_q;
  assign mret_commit = mret_commit_q;
  assign trap_cause  = trap_cause_q;
  assign trap_epc    = trap_epc_q;
  assign flush_req   = flush_req_q;
  assign flush_pc    = flush_pc_q;

endmodule

// File: tb/tb_lieat_exu_trap_ctrl.sv
// Bench for the EXU trap sequencer: a table of one-cycle stimulus records with
// the outputs expected after the following clock edge, plus a hand-written
// asynchronous reset sequence. Expected records go through a scoreboard queue.
module tb_lieat_exu_trap_ctrl;

  localparam int XLEN     = 32;
  localparam int HOLD_TMO = 4;

  localparam logic [31:0] MTVEC  = 32'h8000_0003;
  localparam logic [31:0] MEPC   = 32'h8000_0204;
  localparam logic [31:0] VEC_PC = 32'h8000_0000;
  localparam logic [31:0] C_EC   = 32'd11;
  localparam logic [31:0] C_MSI  = 32'h8000_0003;
  localparam logic [31:0] C_MTI  = 32'h8000_0007;

  logic            clock = 1'b0;
  logic            reset;
  logic            csr_valid, csr_ecall, csr_mret;
  logic [XLEN-1:0] csr_pc;
  logic            mstatus_mie, msip_req, mtip_req;
  logic [XLEN-1:0] mtvec_pc, mepc_pc;
  logic            if_hold_req, if_hold_rsp;
  logic [XLEN-1:0] if_hold_pc;
  logic            exu_stall, trap_commit, mret_commit, flush_req;
  logic [XLEN-1:0] trap_cause, trap_epc, flush_pc;

  always #5 clock = ~clock;

  lieat_exu_trap_ctrl #(.XLEN(XLEN), .HOLD_TMO(HOLD_TMO)) dut (
    .clock       (clock),
    .reset       (reset),
    .csr_valid   (csr_valid),
    .csr_ecall   (csr_ecall),
    .csr_mret    (csr_mret),
    .csr_pc      (csr_pc),
    .mstatus_mie (mstatus_mie),
    .msip_req    (msip_req),
    .mtip_req    (mtip_req),
    .mtvec_pc    (mtvec_pc),
    .mepc_pc     (mepc_pc),
    .if_hold_req (if_hold_req),
    .if_hold_rsp (if_hold_rsp),
    .if_hold_pc  (if_hold_pc),
    .exu_stall   (exu_stall),
    .trap_commit (trap_commit),
    .mret_commit (mret_commit),
    .trap_cause  (trap_cause),
    .trap_epc    (trap_epc),
    .flush_req   (flush_req),
    .flush_pc    (flush_pc)
  );

  typedef struct packed {
    logic        v;
    logic        e;
    logic        m;
    logic [31:0] pc;
    logic        mie;
    logic        msi;
    logic        mti;
    logic        rsp;
    logic [31:0] hpc;
  } in_t;

  typedef struct packed {
    logic        hold;
    logic        stall;
    logic        tc;
    logic        mc;
    logic [31:0] cause;
    logic [31:0] epc;
    logic        fl;
    logic [31:0] fpc;
  } out_t;

  typedef struct {
    string name;
    in_t   stim;
    out_t  exp;
  } vec_t;

  vec_t vecs[$];
  out_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic in_t mk_in(logic v, logic e, logic m, logic [31:0] pc, logic mie,
                                logic msi, logic mti, logic rsp, logic [31:0] hpc);
    in_t r;
    r = '{v: v, e: e, m: m, pc: pc, mie: mie, msi: msi, mti: mti, rsp: rsp, hpc: hpc};
    return r;
  endfunction

  function automatic out_t o_idle();
    out_t r;
    r = '0;
    return r;
  endfunction

  function automatic out_t o_hold();
    out_t r;
    r = '0;
    r.hold = 1'b1;
    r.stall = 1'b1;
    return r;
  endfunction

  function automatic out_t o_trap(logic [31:0] cause, logic [31:0] epc);
    out_t r;
    r = '0;
    r.stall = 1'b1;
    r.tc    = 1'b1;
    r.cause = cause;
    r.epc   = epc;
    r.fl    = 1'b1;
    r.fpc   = VEC_PC;
    return r;
  endfunction

  function automatic out_t o_mret();
    out_t r;
    r = '0;
    r.stall = 1'b1;
    r.mc    = 1'b1;
    r.fl    = 1'b1;
    r.fpc   = MEPC;
    return r;
  endfunction

  function automatic void add(string n, in_t s, out_t o);
    vec_t r;
    r.name = n;
    r.stim = s;
    r.exp  = o;
    vecs.push_back(r);
  endfunction

  task automatic apply(input in_t s);
    csr_valid   = s.v;
    csr_ecall   = s.e;
    csr_mret    = s.m;
    csr_pc      = s.pc;
    mstatus_mie = s.mie;
    msip_req    = s.msi;
    mtip_req    = s.mti;
    if_hold_rsp = s.rsp;
    if_hold_pc  = s.hpc;
  endtask

  task automatic check(input string n);
    out_t a;
    out_t e;
    a = '{hold: if_hold_req, stall: exu_stall, tc: trap_commit, mc: mret_commit,
          cause: trap_cause, epc: trap_epc, fl: flush_req, fpc: flush_pc};
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: scoreboard empty, no expected record", n);
    end else begin
      e = sb_q.pop_front();
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL %s: got hold=%b stall=%b tc=%b mc=%b cause=%h epc=%h fl=%b fpc=%h, want hold=%b stall=%b tc=%b mc=%b cause=%h epc=%h fl=%b fpc=%h",
                 n, a.hold, a.stall, a.tc, a.mc, a.cause, a.epc, a.fl, a.fpc,
                 e.hold, e.stall, e.tc, e.mc, e.cause, e.epc, e.fl, e.fpc);
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    in_t i0, r3, t4, t4e;

    i0  = mk_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    r3  = mk_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    t4  = mk_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    t4e = mk_in(1'b1, 1'b1, 1'b0, 32'h8000_0500, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);

    // ecall, mret, and both together
    add("ecall",       mk_in(1, 1, 0, 32'h8000_0100, 0, 0, 0, 0, 0), o_trap(C_EC, 32'h8000_0100));
    add("ecall_after", i0, o_idle());
    add("mret",        mk_in(1, 0, 1, 32'h8000_0200, 0, 0, 0, 0, 0), o_mret());
    add("mret_after",  i0, o_idle());
    add("ecall_mret",  mk_in(1, 1, 1, 32'h8000_0300, 0, 0, 0, 0, 0), o_trap(C_EC, 32'h8000_0300));
    add("em_after",    i0, o_idle());
    add("irq_masked",  mk_in(0, 0, 0, 0, 0, 1, 1, 0, 0), o_idle());
    // msip and mtip together, response three cycles after the request
    add("irq_req",     r3, o_hold());
    add("irq_wait1",   r3, o_hold());
    add("irq_wait2",   r3, o_hold());
    add("irq_rsp",     mk_in(0, 0, 0, 0, 1, 1, 1, 1, 32'h8000_0040), o_trap(C_MSI, 32'h8000_0040));
    add("irq_commit_exit", mk_in(0, 0, 0, 0, 1, 1, 0, 0, 0), o_idle());
    add("irq_rearb",   mk_in(0, 0, 0, 0, 1, 1, 0, 0, 0), o_hold());
    add("irq_src_drop", mk_in(0, 0, 0, 0, 1, 0, 0, 0, 0), o_idle());
    add("irq_idle",    i0, o_idle());
    // ecall beats mtip, then mtip is taken; timeout with HOLD_TMO=4
    add("ecall_vs_mti", mk_in(1, 1, 0, 32'h8000_0400, 1, 0, 1, 0, 0), o_trap(C_EC, 32'h8000_0400));
    add("mti_commit_exit", t4, o_idle());
    add("mti_hold0",   t4,  o_hold());
    add("mti_hold1",   t4,  o_hold());
    add("mti_hold2_csr_ignored", t4e, o_hold());
    add("mti_hold3",   t4,  o_hold());
    add("mti_timeout", t4,  o_idle());
    add("mti_retry",   t4,  o_hold());
    add("mti_retry1",  t4,  o_hold());
    add("mti_drop",    mk_in(0, 0, 0, 0, 1, 0, 0, 0, 0), o_idle());
    // mie falling aborts the hold
    add("mie_hold",    t4,  o_hold());
    add("mie_drop",    mk_in(0, 0, 0, 0, 0, 0, 1, 0, 0), o_idle());
    // response on the last allowed cycle wins over the timeout
    add("rt_hold0",    t4,  o_hold());
    add("rt_hold1",    t4,  o_hold());
    add("rt_hold2",    t4,  o_hold());
    add("rt_hold3",    t4,  o_hold());
    add("rt_rsp_at_tmo", mk_in(0, 0, 0, 0, 1, 0, 1, 1, 32'h8000_0088), o_trap(C_MTI, 32'h8000_0088));
    add("rt_after",    i0, o_idle());

    mtvec_pc = MTVEC;
    mepc_pc  = MEPC;
    apply(i0);
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    sb_q.push_back(o_idle());
    check("reset_state");
    @(negedge clock);
    reset = 1'b1;

    for (int k = 0; k < vecs.size(); k++) begin
      apply(vecs[k].stim);
      sb_q.push_back(vecs[k].exp);
      tick();
      check(vecs[k].name);
    end

    // Reset pulled low mid-HOLD while a response is pending.
    apply(mk_in(0, 0, 0, 0, 1, 1, 0, 0, 0));
    sb_q.push_back(o_hold());
    tick();
    check("rst_enter_hold");
    apply(mk_in(0, 0, 0, 0, 1, 1, 0, 1, 32'h8000_0080));
    #3;
    reset = 1'b0;
    #1;
    sb_q.push_back(o_idle());
    check("rst_async_clear");
    tick();
    sb_q.push_back(o_idle());
    check("rst_held_edge");
    apply(mk_in(0, 0, 0, 0, 0, 0, 0, 1, 32'h8000_0080));
    @(negedge clock);
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      sb_q.push_back(o_idle());
      tick();
      check("rst_rsp_alone");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
